// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants for the instruction-memory loader.
//   - FSM state encoding (LEN/DATA/WRITE/DONE/ERR)
//   - BYTES_PER_WORD: stream bytes per memory word
//   - CNT_W: width of the words-written counter
package imem_loader_pkg;

  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 11;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: gathers big-endian bytes into a 32-bit word.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   clear           drop any partial word (state entry)
//   load            a byte is accepted this cycle
//   byte_in         the accepted byte
//   word            assembled word including the byte being loaded now
//   word_complete   high while the 4th byte of a word is being loaded
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from byte_in so the full word is usable on the accepting edge.
  logic [23:0] shreg;
  logic [1:0]  cnt;

  assign word          = {shreg, byte_in};
  assign word_complete = load && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= {shreg[15:0], byte_in};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed big-endian byte stream into the
// instruction memory and holds the core in reset until the image is loaded.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   byte_valid/byte_data/byte_ready   valid/ready byte source
//   mem_write/mem_address/mem_write_data   memory write port
//   cpu_reset                  core reset, high until load completes
//   done / error               load finished / length header too large
//   words_written              words written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  logic [2:0]       state, state_next;
  logic [31:0]      len;
  logic [31:0]      word;
  logic             word_complete;
  logic             xfer;
  logic [CNT_W-1:0] ww_inc;

  assign xfer   = byte_valid && byte_ready;
  assign ww_inc = words_written + 1'b1;

  // One assembler serves both the length header and the data words; it is
  // cleared whenever the FSM changes state.
  byte_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (state_next != state),
    .load          (xfer),
    .byte_in       (byte_data),
    .word          (word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_LEN:
        if (word_complete) begin
          if (word == 32'd0)                 state_next = ST_DONE;
          else if (word > 32'(MEM_WORDS))    state_next = ST_ERR;
          else                               state_next = ST_DATA;
        end
      ST_DATA:
        if (word_complete) state_next = ST_WRITE;
      ST_WRITE:
        state_next = (32'(ww_inc) == len) ? ST_DONE : ST_DATA;
      default:
        state_next = state;
    endcase
  end

  // All outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_LEN;
      len            <= '0;
      byte_ready     <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= BASE_ADDR;
      mem_write_data <= '0;
      cpu_reset      <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      words_written  <= '0;
    end else begin
      state      <= state_next;
      byte_ready <= (state_next == ST_LEN) || (state_next == ST_DATA);
      mem_write  <= (state_next == ST_WRITE);
      done       <= (state_next == ST_DONE);
      error      <= (state_next == ST_ERR);
      cpu_reset  <= (state_next != ST_DONE);
      if (state == ST_LEN && word_complete)
        len <= word;
      // Address/data only move when entering WRITE, so they stay stable
      // for the whole write cycle and in between.
      if (state == ST_DATA && word_complete) begin
        mem_write_data <= word;
        mem_address    <= BASE_ADDR + 32'({words_written, 2'b00});
      end
      if (state == ST_WRITE)
        words_written <= ww_inc;
    end
  end

endmodule
